vote_collector: RTL and testbench
=================================

# vote_collector

Serial-to-parallel front end for the 7-input ones-count/encoder stage. Collects seven single-bit samples from a serial source under a valid handshake and assembles them into the 7-bit vector the downstream combinational stage consumes. A one-cycle `vec_valid` pulse marks each completed vector. The vector is held stable until the next frame starts, so the combinational stage can be sampled at any time.

## Interface
- `WIDTH`, 7: number of bits per frame; must equal the downstream stage's input width.
- `CNT_W`, 3: width of the bit counter; must satisfy 2**CNT_W > WIDTH.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begins a new frame; honoured in any state.
- `abort`  in  1  drops the current frame; returns to IDLE without a valid pulse.
- `bit_in`  in  1  serial data sample.
- `bit_valid`  in  1  `bit_in` is valid this cycle.
- `ready`  out  1  high while the block accepts `bit_in` (COLLECT state only).
- `vec`  out  WIDTH  assembled vector; bit i is the i-th accepted sample (LSB first).
- `vec_valid`  out  1  one-cycle pulse when `vec` completes.
- `bit_count`  out  CNT_W  number of samples accepted in the current frame.
- `busy`  out  1  high in COLLECT and DONE.

## Operation
- Reset (`rst_n`=0 at a clock edge) sets state=IDLE, `vec`=0, `bit_count`=0, `vec_valid`=0, `ready`=0, `busy`=0. Reset overrides all other inputs.
- **IDLE**
  - `bit_valid` is ignored.
  - `start`=1 moves to COLLECT and clears `vec` and `bit_count`.
  - `vec` otherwise holds its last completed frame.
- **COLLECT**
  - `ready`=1.
  - A sample is accepted when `bit_valid`=1. The block writes `vec[bit_count]` ← `bit_in` and increments `bit_count`.
  - The accept that makes `bit_count` reach WIDTH moves to DONE.
- **DONE**
  - Lasts one cycle.
  - `vec_valid`=1, `ready`=0.
  - Moves to IDLE unconditionally unless `start` is asserted.
- **Priority each cycle:** `rst_n` > `abort` > `start` > `bit_valid`.
  - `abort` in any state: go to IDLE and clear `bit_count`. `vec` keeps its partial contents. No pulse is issued.
  - `start` in COLLECT: restart the frame, clearing `vec` and `bit_count`. A same-cycle `bit_valid` is discarded.
  - `start` in DONE: `vec_valid` still pulses this cycle, then the block enters COLLECT with cleared state.
- **Width rules:** `bit_count` never exceeds WIDTH. Writes to `vec` index strictly below WIDTH.

## Timing
- Output latency:
  - `ready` rises the cycle after `start` is sampled.
  - `vec_valid` rises the cycle after the WIDTH-th accept.
  - Minimum frame is WIDTH+2 cycles from `start` to `vec_valid`.
- Timing of `vec`:
  - Each `vec` bit updates at the edge that accepts it.
  - The full vector is stable from the `vec_valid` cycle until the next `start` or reset.
- All outputs are registered except `ready` and `busy`, which are decoded from the state register.
- Back-to-back samples on consecutive cycles are supported. Gaps in `bit_valid` simply stall the frame.

## Structure
- Shared package `vote_pkg`:
  - `VOTE_W`=7.
  - `VOTE_CNT_W`=3.
  - `typedef enum logic [1:0] {IDLE, COLLECT, DONE} vc_state_t`.
- One sub-module, `mod_counter`:
  - Parameterised up-counter with synchronous clear and enable.
  - Drives `bit_count` and the terminal-count flag.
- FSM and shift/write logic live in `vote_collector`. No other hierarchy.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `start`=1 and `bit_valid`=1 → every output is 0, state is IDLE.
- **Basic frame:** `start`, then bits 1,0,1,1,0,0,1 on consecutive cycles → `vec`=7'b1001101, `vec_valid` pulses exactly once, 9 cycles after `start`. Downstream count reads 4.
- **Gapped input:** same bits with `bit_valid` low for 2 cycles between every sample → identical `vec`. `bit_count` steps 0..7 only on accepts.
- **Restart:** `start`, 4 bits of 1, then `start` again with `bit_valid`=1 that cycle, then 7 zeros → `vec`=0. Exactly one `vec_valid` pulse.
- **Abort:** `start`, 3 bits of 1, then `abort` → IDLE, no pulse, `bit_count`=0. Next frame of seven 1s → `vec`=7'h7F.
- **Reset mid-frame and idle inputs:** pulse `rst_n` low after 5 bits → `vec`=0 and no pulse. In IDLE, `bit_valid`=1 without `start` → `vec` unchanged.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and sizes for the vote collector front end.
package vote_pkg;

    localparam int unsigned VOTE_W     = 7;
    localparam int unsigned VOTE_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } vc_state_t;

endpackage

// File: rtl/vote_collector_if.sv
// Serial sample handshake and assembled-vector outputs of the vote collector.
interface vote_collector_if
    import vote_pkg::*;
#(
    parameter int unsigned WIDTH = VOTE_W,
    parameter int unsigned CNT_W = VOTE_CNT_W
);
    logic             start;
    logic             abort;
    logic             bit_in;
    logic             bit_valid;
    logic             ready;
    logic [WIDTH-1:0] vec;
    logic             vec_valid;
    logic [CNT_W-1:0] bit_count;
    logic             busy;

    modport master (
        output start, abort, bit_in, bit_valid,
        input  ready, vec, vec_valid, bit_count, busy
    );

    modport slave (
        input  start, abort, bit_in, bit_valid,
        output ready, vec, vec_valid, bit_count, busy
    );
endinterface

// File: rtl/mod_counter.sv
// Saturating up-counter with synchronous clear/enable and a last-step flag.
module mod_counter #(
    parameter int unsigned W     = 3,
    parameter int unsigned LIMIT = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         at_last_c
);
    localparam logic [W-1:0] TOP_V  = W'(LIMIT);
    localparam logic [W-1:0] LAST_V = W'(LIMIT - 1);

    // Never counts past LIMIT, even if enable stays high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != TOP_V)) begin
            count <= count + W'(1);
        end
    end

    assign at_last_c = (count == LAST_V);
endmodule

// File: rtl/vote_collector.sv
// Collects WIDTH serial samples into a parallel vector with a completion pulse.
module vote_collector
    import vote_pkg::*;
#(
    parameter int unsigned WIDTH = VOTE_W,
    parameter int unsigned CNT_W = VOTE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    vote_collector_if.slave  bus
);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(WIDTH);

    vc_state_t        state_q;
    vc_state_t        state_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_last;
    logic             vec_clr;
    logic             vec_wr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] vec_q;
    logic             vec_valid_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath controls; abort beats start beats bit_valid.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        vec_clr = 1'b0;
        vec_wr  = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else if (bus.start) begin
            state_d = COLLECT;
            cnt_clr = 1'b1;
            vec_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                COLLECT: begin
                    if (bus.bit_valid) begin
                        cnt_en = 1'b1;
                        vec_wr = 1'b1;
                        if (cnt_last) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    mod_counter #(
        .W     (CNT_W),
        .LIMIT (WIDTH)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .count     (count),
        .at_last_c (cnt_last)
    );

    // Sample write; the index guard keeps writes inside the vector.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else if (vec_clr) begin
            vec_q <= '0;
        end else if (vec_wr && (count < LIMIT_V)) begin
            vec_q[count] <= bus.bit_in;
        end
    end

    // Pulse is high exactly while the FSM sits in DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec_valid_q <= 1'b0;
        end else begin
            vec_valid_q <= (state_d == DONE);
        end
    end

    assign bus.vec       = vec_q;
    assign bus.vec_valid = vec_valid_q;
    assign bus.bit_count = count;
    assign bus.ready     = (state_q == COLLECT);
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_vote_collector.sv
// Directed scoreboard bench for vote_collector: stimulus queues expected frames, a monitor checks pulses.
module tb_vote_collector;
    import vote_pkg::*;

    typedef struct {
        logic [VOTE_W-1:0] v;
        int                ones;
        int                t0;
        int                lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    exp_t exp_q[$];

    vote_collector_if bus ();

    vote_collector dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: every vec_valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.vec_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_vec", 32'(bus.vec), 32'(e.v));
                chk("frame_ones", 32'($countones(bus.vec)), 32'(e.ones));
                if (e.lat != 0) chk("frame_latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        step();
        bus.bit_valid = 1'b0;
    endtask

    task automatic push(input logic [VOTE_W-1:0] v, input int ones, input int lat);
        exp_t e;
        e.v    = v;
        e.ones = ones;
        e.t0   = cyc;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    // Start-sample edge through the pulse cycle: WIDTH+2 cycles inclusive.
    localparam int LAT = VOTE_W + 1;

    logic [VOTE_W-1:0] pat;
    logic [VOTE_W-1:0] alt;

    initial begin
        total = 0;
        bad   = 0;
        pat   = 7'b1001101;
        alt   = 7'b0101010;
        rst_n         = 1'b0;
        bus.start     = 1'b1;
        bus.abort     = 1'b0;
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_vec", 32'(bus.vec), 32'd0);
        chk("rst_vec_valid", 32'(bus.vec_valid), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bit_count", 32'(bus.bit_count), 32'd0);
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        step();

        // Basic back-to-back frame.
        push(pat, 4, LAT);
        do_start();
        @(negedge clk);
        chk("basic_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < VOTE_W; i++) send_bit(pat[i]);
        repeat (3) step();
        @(negedge clk);
        chk("basic_hold", 32'(bus.vec), 32'(pat));
        chk("basic_idle_busy", 32'(bus.busy), 32'd0);

        // Gapped input: count moves only on accepts.
        push(pat, 4, 0);
        do_start();
        @(negedge clk);
        chk("gap_count0", 32'(bus.bit_count), 32'd0);
        for (int i = 0; i < VOTE_W; i++) begin
            send_bit(pat[i]);
            @(negedge clk);
            chk("gap_count_acc", 32'(bus.bit_count), 32'(i + 1));
            if (i < VOTE_W - 1) begin
                step();
                step();
                @(negedge clk);
                chk("gap_count_hold", 32'(bus.bit_count), 32'(i + 1));
            end
        end
        repeat (3) step();

        // Restart mid-frame with a same-cycle sample that must be dropped.
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        push(7'h00, 0, LAT);
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        @(negedge clk);
        chk("restart_count", 32'(bus.bit_count), 32'd0);
        chk("restart_vec", 32'(bus.vec), 32'd0);
        for (int i = 0; i < VOTE_W; i++) send_bit(1'b0);
        repeat (3) step();

        // Abort keeps partial vec, clears count, no pulse.
        do_start();
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ready", 32'(bus.ready), 32'd0);
        chk("abort_count", 32'(bus.bit_count), 32'd0);
        chk("abort_vec", 32'(bus.vec), 32'h07);
        repeat (2) step();

        // Seven ones, then start during DONE launches the next frame.
        push(7'h7F, 7, LAT);
        do_start();
        for (int i = 0; i < VOTE_W; i++) send_bit(1'b1);
        push(alt, 3, LAT);
        do_start();
        @(negedge clk);
        chk("done_start_ready", 32'(bus.ready), 32'd1);
        for (int i = 0; i < VOTE_W; i++) send_bit(alt[i]);
        repeat (3) step();

        // Reset mid-frame, then idle samples without start.
        do_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_vec", 32'(bus.vec), 32'd0);
        chk("midrst_count", 32'(bus.bit_count), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        repeat (3) step();
        bus.bit_valid = 1'b0;
        @(negedge clk);
        chk("idle_vec", 32'(bus.vec), 32'd0);
        chk("idle_count", 32'(bus.bit_count), 32'd0);
        chk("idle_ready", 32'(bus.ready), 32'd0);
        repeat (10) step();

        chk("missing_pulses", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
